pc_unit: RTL and testbench
==========================

# pc_unit

Registered program-counter unit for the fetch stage, superseding the combinational next-PC calculator. Holds the fetch address and drives it to instruction memory over a valid/ready handshake. Applies conditional PC-relative branch redirects from execute, including redirects that arrive while fetch is stalled. Also produces the branch-and-link write and a one-cycle pipeline flush pulse.

## Interface
- ADDR_W, 32, PC / address width
- INCR, 4, sequential fetch increment (bytes)
- OFFSET_W, 24, branch offset field width
- OFFSET_SHIFT, 2, left shift applied to sign-extended offset
- PIPE_AHEAD, 8, architectural PC read-ahead added to branch_pc when forming a target
- RESET_VEC, 0, first fetch address after reset

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain only
- fetch_valid  out  1  fetch request valid
- fetch_addr  out  ADDR_W  fetch address
- fetch_ready  in  1  imem accepts request when fetch_valid && fetch_ready
- br_valid  in  1  execute presents a branch this cycle
- br_cond  in  1  condition passed; branch is taken only if br_valid && br_cond
- br_link  in  1  branch-with-link
- br_pc  in  ADDR_W  address of the branch instruction
- br_offset  in  OFFSET_W  raw signed word offset field
- flush  out  1  one-cycle pulse: discard younger in-flight instructions
- link_we  out  1  one-cycle link-register write strobe
- link_data  out  ADDR_W  return address

## Operation
- taken = br_valid && br_cond. Not-taken branches have no effect: no flush, no link.
- target = br_pc + PIPE_AHEAD + (sext(br_offset) << OFFSET_SHIFT).
  - Sign extension is to ADDR_W bits.
  - The sum is modulo 2^ADDR_W; wrap-around is silent.
- States:
  - IDLE (reset state): fetch_valid=0, fetch_addr=RESET_VEC. Goes unconditionally to FETCH next cycle. br_* inputs are ignored in IDLE.
  - FETCH: fetch_valid=1.
    - taken && fetch_ready: fetch_addr<=target; stay in FETCH.
    - taken && !fetch_ready: pend<=target; fetch_addr held; go to PEND.
    - !taken && fetch_ready: fetch_addr<=fetch_addr+INCR (modulo 2^ADDR_W).
    - !taken && !fetch_ready: hold.
  - PEND: fetch_valid=1; fetch_addr is held at the stalled request.
    - fetch_ready: fetch_addr<=pend; go to FETCH.
    - Further taken branches in PEND are ignored: no flush, no link. They are wrong-path instructions.
- Handshake rule: while fetch_valid && !fetch_ready, fetch_addr must not change. The PEND state exists to guarantee this.
- In FETCH and PEND, every sampled-and-accepted taken branch produces, one cycle later:
  - flush=1.
  - If br_link: link_we=1 and link_data = br_pc + INCR (modulo 2^ADDR_W).
- The request accepted on the cycle a redirect is sampled is wrong-path; downstream discards it on flush.

## Timing
- Reset values: fetch_valid=0, fetch_addr=RESET_VEC, flush=0, link_we=0, link_data=0, state=IDLE, pend=0.
- Reset is asynchronous. Asserting it mid-operation, including in PEND, returns all outputs to their reset values immediately and discards pend.
- First valid fetch appears on the 2nd rising edge after reset deasserts. On that edge fetch_valid becomes 1 with fetch_addr=RESET_VEC.
- Redirect latency:
  - Target appears on fetch_addr 1 cycle after sampling when ready.
  - Otherwise it appears 1 cycle after the first fetch_ready=1 in PEND.
- flush and link_we are registered, single-cycle, and independent of fetch_ready.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset release, fetch_ready=1 constant:
  - fetch_valid low for 1 cycle.
  - Then fetch_addr = 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- fetch_ready=0 for 3 cycles at fetch_addr=0x10: address held at 0x10, fetch_valid=1 throughout. Advances to 0x14 on the first ready.
- Taken branch with ready=1, br_pc=0x100, br_offset=0x000010, br_link=1:
  - Next cycle fetch_addr=0x148, flush=1.
  - link_we=1 with link_data=0x104, each for exactly 1 cycle.
- Taken branch with ready=0, br_pc=0x200, br_offset=0xFFFFFE (−2 words):
  - Enters PEND with fetch_addr held.
  - A second taken branch 1 cycle later gives no flush.
  - On ready: fetch_addr=0x200.
- Wrap and not-taken:
  - br_pc=0xFFFFFFF8, offset=0, taken: fetch_addr=0x00000000.
  - br_valid=1, br_cond=0: sequential +4, no flush.
- Reset asserted asynchronously while in PEND: outputs reset immediately without waiting for a clock edge. After release, fetch restarts at RESET_VEC with no pending redirect applied.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch/branch/link bundle between the program-counter unit (master) and
// the surrounding fetch/execute logic (slave).
interface pc_unit_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 24
);
  logic                fetch_valid;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fetch_ready;
  logic                br_valid;
  logic                br_cond;
  logic                br_link;
  logic [ADDR_W-1:0]   br_pc;
  logic [OFFSET_W-1:0] br_offset;
  logic                flush;
  logic                link_we;
  logic [ADDR_W-1:0]   link_data;

  modport master (
    output fetch_valid, fetch_addr, flush, link_we, link_data,
    input  fetch_ready, br_valid, br_cond, br_link, br_pc, br_offset
  );

  modport slave (
    input  fetch_valid, fetch_addr, flush, link_we, link_data,
    output fetch_ready, br_valid, br_cond, br_link, br_pc, br_offset
  );
endinterface

// File: rtl/pc_unit.sv
// Registered fetch-stage program counter: valid/ready fetch requests, PC-relative
// branch redirects (held pending across stalls), link write and flush pulse.
module pc_unit #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        INCR         = 4,
  parameter int unsigned        OFFSET_W     = 24,
  parameter int unsigned        OFFSET_SHIFT = 2,
  parameter int unsigned        PIPE_AHEAD   = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC    = '0
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PEND  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              flush_q, flush_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;

  logic              taken;
  logic              accept_br;
  logic [ADDR_W-1:0] offset_ext;
  logic [ADDR_W-1:0] target;

  always_comb begin
    taken      = bus.br_valid && bus.br_cond;
    offset_ext = {{(ADDR_W-OFFSET_W){bus.br_offset[OFFSET_W-1]}}, bus.br_offset};
    target     = bus.br_pc + ADDR_W'(PIPE_AHEAD) + (offset_ext << OFFSET_SHIFT);
  end

  // IDLE is held through the first edge after reset release (armed_q), so the
  // first valid request lands on the second rising edge.
  always_comb begin
    state_d       = state_q;
    armed_d       = 1'b1;
    fetch_valid_d = fetch_valid_q;
    fetch_addr_d  = fetch_addr_q;
    pend_d        = pend_q;
    accept_br     = 1'b0;
    unique case (state_q)
      IDLE: begin
        fetch_valid_d = 1'b0;
        fetch_addr_d  = RESET_VEC;
        if (armed_q) begin
          state_d       = FETCH;
          fetch_valid_d = 1'b1;
        end
      end
      FETCH: begin
        fetch_valid_d = 1'b1;
        accept_br     = taken;
        if (taken && bus.fetch_ready) begin
          fetch_addr_d = target;
        end else if (taken) begin
          pend_d  = target;
          state_d = PEND;
        end else if (bus.fetch_ready) begin
          fetch_addr_d = fetch_addr_q + ADDR_W'(INCR);
        end
      end
      PEND: begin
        fetch_valid_d = 1'b1;
        if (bus.fetch_ready) begin
          fetch_addr_d = pend_q;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d       = IDLE;
        fetch_valid_d = 1'b0;
        fetch_addr_d  = RESET_VEC;
      end
    endcase
  end

  always_comb begin
    flush_d     = accept_br;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    if (accept_br && bus.br_link) begin
      link_we_d   = 1'b1;
      link_data_d = bus.br_pc + ADDR_W'(INCR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= RESET_VEC;
      pend_q        <= '0;
      flush_q       <= 1'b0;
      link_we_q     <= 1'b0;
      link_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
      pend_q        <= pend_d;
      flush_q       <= flush_d;
      link_we_q     <= link_we_d;
      link_data_q   <= link_data_d;
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.flush       = flush_q;
  assign bus.link_we     = link_we_q;
  assign bus.link_data   = link_data_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and random checks of pc_unit against a queue-based behavioural model.
module tb_pc_unit;

  logic clk;
  logic reset;

  pc_unit_if #(.ADDR_W(32), .OFFSET_W(24)) bus ();

  pc_unit #(
    .ADDR_W(32), .INCR(4), .OFFSET_W(24), .OFFSET_SHIFT(2),
    .PIPE_AHEAD(8), .RESET_VEC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned fails  = 0;
  int unsigned checks = 0;

  // Behavioural model: edges since reset release, fetch PC, and a queue
  // holding a redirect that could not be issued while the fetch was stalled.
  int unsigned  m_edges;
  logic         m_valid;
  logic [31:0]  m_addr;
  logic [31:0]  m_pend[$];
  logic         m_flush;
  logic         m_lwe;
  logic [31:0]  m_ldata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [23:0] off);
    int signed words;
    words = off[23] ? (int'(off) - (1 << 24)) : int'(off);
    return pc + 32'd8 + 32'(words * 4);
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_valid = 1'b0;
    m_addr  = 32'h0;
    m_pend.delete();
    m_flush = 1'b0;
    m_lwe   = 1'b0;
    m_ldata = 32'h0;
  endtask

  task automatic model_edge();
    logic took;
    took = 1'b0;
    m_edges++;
    if (m_edges == 2) begin
      m_valid = 1'b1;
      m_addr  = 32'h0;
    end else if (m_edges > 2) begin
      if (m_pend.size() == 0) begin
        took = bus.br_valid && bus.br_cond;
        if (took && bus.fetch_ready) m_addr = branch_target(bus.br_pc, bus.br_offset);
        else if (took) m_pend.push_back(branch_target(bus.br_pc, bus.br_offset));
        else if (bus.fetch_ready) m_addr = m_addr + 32'd4;
      end else if (bus.fetch_ready) begin
        m_addr = m_pend.pop_front();
      end
    end
    m_flush = took;
    m_lwe   = took && bus.br_link;
    if (m_lwe) m_ldata = bus.br_pc + 32'd4;
  endtask

  task automatic compare_model(input string ctx);
    chk({ctx, ".valid"}, 32'(bus.fetch_valid), 32'(m_valid));
    chk({ctx, ".addr"},  bus.fetch_addr, m_addr);
    chk({ctx, ".flush"}, 32'(bus.flush), 32'(m_flush));
    chk({ctx, ".lwe"},   32'(bus.link_we), 32'(m_lwe));
    chk({ctx, ".ldata"}, bus.link_data, m_ldata);
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(ctx);
  endtask

  task automatic set_br(input logic v, input logic c, input logic l,
                        input logic [31:0] pc, input logic [23:0] off);
    bus.br_valid  = v;
    bus.br_cond   = c;
    bus.br_link   = l;
    bus.br_pc     = pc;
    bus.br_offset = off;
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_ready = 1'b1;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 24'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    reset = 1'b0;

    // Reset release with constant ready
    tick("rel1");
    chk("rel1_valid_low", 32'(bus.fetch_valid), 32'd0);
    tick("rel2");
    chk("first_fetch", bus.fetch_addr, 32'h0);
    chk("first_valid", 32'(bus.fetch_valid), 32'd1);
    tick("seq4");
    chk("seq_0x4", bus.fetch_addr, 32'h4);
    tick("seq8");
    tick("seqC");
    chk("seq_0xC", bus.fetch_addr, 32'hC);
    tick("seq10");

    // Stall at 0x10
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_hold", bus.fetch_addr, 32'h10);
    end
    bus.fetch_ready = 1'b1;
    tick("unstall");
    chk("unstall_0x14", bus.fetch_addr, 32'h14);

    // Taken branch with link, ready high
    set_br(1'b1, 1'b1, 1'b1, 32'h100, 24'h000010);
    tick("br_link");
    chk("br_target", bus.fetch_addr, 32'h148);
    chk("br_flush", 32'(bus.flush), 32'd1);
    chk("br_lwe", 32'(bus.link_we), 32'd1);
    chk("br_ldata", bus.link_data, 32'h104);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 24'h0);
    tick("br_after");
    chk("flush_one_cycle", 32'(bus.flush), 32'd0);
    chk("lwe_one_cycle", 32'(bus.link_we), 32'd0);

    // Taken branch while stalled, then a wrong-path branch in PEND
    bus.fetch_ready = 1'b0;
    set_br(1'b1, 1'b1, 1'b0, 32'h200, 24'hFFFFFE);
    tick("pend_enter");
    chk("pend_hold", bus.fetch_addr, 32'h14C);
    chk("pend_flush", 32'(bus.flush), 32'd1);
    set_br(1'b1, 1'b1, 1'b1, 32'h300, 24'h0);
    tick("pend_2nd");
    chk("pend_no_flush", 32'(bus.flush), 32'd0);
    chk("pend_no_link", 32'(bus.link_we), 32'd0);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 24'h0);
    bus.fetch_ready = 1'b1;
    tick("pend_exit");
    chk("pend_target", bus.fetch_addr, 32'h200);

    // Wrap-around target, then a not-taken branch
    set_br(1'b1, 1'b1, 1'b0, 32'hFFFFFFF8, 24'h0);
    tick("wrap");
    chk("wrap_zero", bus.fetch_addr, 32'h0);
    set_br(1'b1, 1'b0, 1'b1, 32'h700, 24'h10);
    tick("nottaken");
    chk("nt_seq", bus.fetch_addr, 32'h4);
    chk("nt_flush", 32'(bus.flush), 32'd0);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 24'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      set_br($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
             $urandom, 24'($urandom));
      tick("rand");
    end

    // Guarantee a non-zero link value, then enter PEND and reset asynchronously
    bus.fetch_ready = 1'b1;
    set_br(1'b1, 1'b1, 1'b1, 32'h400, 24'h4);
    tick("pre_rst_link");
    bus.fetch_ready = 1'b0;
    set_br(1'b1, 1'b1, 1'b0, 32'h500, 24'h20);
    tick("pre_rst_pend");
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 24'h0);
    tick("in_pend");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_model("async_rst");
    @(posedge clk);
    #1;
    compare_model("rst_held");
    reset = 1'b0;
    bus.fetch_ready = 1'b1;
    tick("rerel1");
    tick("rerel2");
    chk("restart_vec", bus.fetch_addr, 32'h0);
    tick("rerel3");
    chk("no_stale_pend", bus.fetch_addr, 32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
